// File: rtl/demux18_deser.sv
// rtl/demux18_deser.sv - serial-to-parallel receiver that steps the mux81 select and rebuilds the word
// Drives S onto the upstream mux select and samples its Y output on din once per enabled step.
module demux18_deser #(
  parameter int N         = 8,
  parameter int SW        = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          en,
  input  logic          din,
  output logic [SW-1:0] S,
  output logic [N-1:0]  I,
  output logic          busy,
  output logic          valid
);

  localparam logic [SW-1:0] S_FIRST = MSB_FIRST ? SW'(N - 1) : '0;
  localparam logic [SW-1:0] S_LAST  = MSB_FIRST ? '0 : SW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [N-1:0]  word_q, word_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      SHIFT: begin
        busy_d = 1'b1;
        if (en) begin
          shreg_d[s_q] = din;
          if (s_q == S_LAST) begin
            // The final bit goes straight into the published word, not via shreg_q.
            word_d  = shreg_d;
            state_d = DONE;
            s_d     = S_FIRST;
            busy_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
            s_d = MSB_FIRST ? s_q - SW'(1) : s_q + SW'(1);
          end
        end
      end
      default: begin
        s_d = S_FIRST;
        if (start) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= S_FIRST;
      shreg_q <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign S     = s_q;
  assign I     = word_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule
